tiny_dnn_seq: RTL

Parametrised successor of the tiny-dnn bfloat16 MAC array. It holds `F_NUM` per-channel weight memories of depth `F_SIZE`. An internal sequencer runs a dot-product pass of programmable length over a handshaked activation stream. It then streams the per-channel fp32 results, with optional ReLU, out through a valid/ready port, so the host no longer drives the exec, address and normalize-select signals cycle by cycle.

---
 rtl/tiny_dnn_seq_if.sv | 36 +++
 rtl/tiny_dnn_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_seq_if.sv
// Host-side bundle of tiny_dnn_seq: weight access, pass control, activation stream and result stream.
// The host drives the master modport; the MAC array sits on the slave modport.
interface tiny_dnn_seq_if #(
    parameter int F_NUM  = 16,
    parameter int F_SIZE = 512,
    parameter int CW     = $clog2(F_NUM),
    parameter int AW     = $clog2(F_SIZE)
);
    logic              write;
    logic              read;
    logic [CW+AW-1:0]  a;
    logic [31:0]       d;
    logic [31:0]       x;
    logic              start;
    logic [AW:0]       len;
    logic              relu;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_ch;
    logic [31:0]       out_data;
    logic              busy;
    logic              done;

    modport master (
        output write, read, a, d, start, len, relu, in_valid, in_data, out_ready,
        input  x, in_ready, out_valid, out_ch, out_data, busy, done
    );

    modport slave (
        input  write, read, a, d, start, len, relu, in_valid, in_data, out_ready,
        output x, in_ready, out_valid, out_ch, out_data, busy, done
    );
endinterface

// File: rtl/tiny_dnn_seq.sv
// Sequenced bfloat16 MAC array: F_NUM channels dot a handshaked activation stream against per-channel weights.
// First result 3 cycles after the last accept, 1 bubble per channel advance; results stall on out_ready=0.
module tiny_dnn_seq #(
    parameter int F_NUM  = 16,
    parameter int F_SIZE = 512,
    parameter int CW     = $clog2(F_NUM),
    parameter int AW     = $clog2(F_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    tiny_dnn_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    // Unnormalised accumulator: value = (-1)^s * m * 2^(e - 268), m two's complement
    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [31:0] m;
    } acc_t;

    state_t          state;
    logic [AW:0]     k;
    logic [AW:0]     len_q;
    logic            relu_q;
    logic            drain_cnt;
    logic [CW-1:0]   out_ch;
    logic            out_valid;
    logic [31:0]     out_data;
    logic            done;
    logic [15:0]     x_q;

    logic [15:0]     wmem [F_NUM][F_SIZE];
    logic [15:0]     w_q  [F_NUM];
    logic [15:0]     v_q;
    logic            s1_vld;
    acc_t            acc  [F_NUM];

    logic [CW-1:0]   a_ch;
    logic [AW-1:0]   a_wd;
    logic            in_ready;
    logic            accept;
    logic            unused_d;

    assign a_ch     = bus.a[CW+AW-1:AW];
    assign a_wd     = bus.a[AW-1:0];
    assign in_ready = (state == RUN) && (k < len_q);
    assign accept   = in_ready && bus.in_valid;
    assign unused_d = ^bus.d[15:0];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_ch    = out_ch;
    assign bus.out_data  = out_data;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
    assign bus.x         = {16'h0000, x_q};

    function automatic acc_t mac_step(input acc_t cur, input logic [15:0] w, input logic [15:0] v);
        acc_t              nxt;
        logic [15:0]       p;
        logic [8:0]        em;
        logic signed [11:0] dl;
        logic [31:0]       a_al;
        logic signed [48:0] t;
        logic              ps;
        logic              fits;
        nxt  = cur;
        ps   = w[15] ^ v[15];
        p    = {8'h00, 1'b1, w[6:0]} * {8'h00, 1'b1, v[6:0]};
        em   = {1'b0, w[14:7]} + {1'b0, v[14:7]};
        dl   = $signed({3'b000, em}) - $signed({{2{cur.e[9]}}, cur.e}) + 12'sd16;
        a_al = (cur.s != ps) ? -cur.m : cur.m;
        t    = '0;
        // Shifts past 63 leave nothing of the old accumulator
        if (!dl[11] && dl[11:6] == 6'd0)
            t = $signed({a_al[31], a_al, 16'h0000}) >>> dl[5:0];
        fits = (&t[48:30]) | (~|t[48:30]);
        if (w[14:7] != 8'h00 && v[14:7] != 8'h00 && !dl[11] && fits) begin
            nxt.s = ps;
            nxt.e = {1'b0, em};
            nxt.m = {16'h0000, p} + t[31:0];
        end
        return nxt;
    endfunction

    function automatic logic [31:0] norm(input acc_t cur, input logic rl);
        logic [31:0]        mag;
        logic [31:0]        sh;
        logic               sg;
        logic [5:0]         lz;
        logic signed [11:0] e;
        logic [31:0]        res;
        mag = cur.m[31] ? -cur.m : cur.m;
        sg  = cur.m[31] ? ~cur.s : cur.s;
        lz  = 6'd32;
        for (int i = 0; i < 32; i++)
            if (mag[i]) lz = 6'(31 - i);
        e   = $signed({{2{cur.e[9]}}, cur.e}) - $signed({6'b000000, lz}) + 12'sd17 - 12'sd127;
        sh  = mag << lz;
        res = {sg, e[7:0], sh[30:8]};
        if (mag == 32'h0 || e[11] || e == 12'sd0 || (rl && sg))
            res = 32'h0;
        return res;
    endfunction

    // Weight storage and the MAC operand stage carry no reset; weights survive a reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.write)
            wmem[a_ch][a_wd] <= bus.d[31:16];
        if (accept) begin
            for (int c = 0; c < F_NUM; c++)
                w_q[c] <= wmem[c][k[AW-1:0]];
            v_q <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            len_q     <= '0;
            relu_q    <= 1'b0;
            drain_cnt <= 1'b0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            x_q       <= '0;
            s1_vld    <= 1'b0;
            for (int c = 0; c < F_NUM; c++)
                acc[c] <= '0;
        end else begin
            done   <= 1'b0;
            s1_vld <= accept;
            if (s1_vld) begin
                for (int c = 0; c < F_NUM; c++)
                    acc[c] <= mac_step(acc[c], w_q[c], v_q);
            end
            case (state)
                IDLE: begin
                    if (bus.read)
                        x_q <= wmem[a_ch][a_wd];
                    if (bus.start) begin
                        for (int c = 0; c < F_NUM; c++)
                            acc[c] <= '0;
                        k      <= '0;
                        len_q  <= bus.len;
                        relu_q <= bus.relu;
                        out_ch <= '0;
                        state  <= (bus.len == '0) ? OUT : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        k <= k + 1'b1;
                        if (k + 1'b1 == len_q) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    // Second drain cycle: last MAC has landed, preload channel 0
                    if (drain_cnt) begin
                        out_data  <= norm(acc[0], relu_q);
                        out_valid <= 1'b1;
                        out_ch    <= '0;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_valid) begin
                        if (bus.out_ready) begin
                            out_valid <= 1'b0;
                            if (out_ch == CW'(F_NUM - 1)) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                out_ch <= out_ch + 1'b1;
                            end
                        end
                    end else begin
                        out_data  <= norm(acc[out_ch], relu_q);
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
